// File: rtl/pseudo_spi_xfer_ctrl_if.sv
// Bus bundle between the transfer controller, its SRAM port, the serial scan chain and the CPU/test controller.
interface pseudo_spi_xfer_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned DIV_WIDTH  = 8
);
   logic                  bgn;
   logic                  mode;
   logic [ADDR_WIDTH-1:0] addr_bgn;
   logic [LEN_WIDTH-1:0]  data_len;
   logic [DIV_WIDTH-1:0]  freq_div;
   logic [DATA_WIDTH-1:0] pi;
   logic                  spi_si;
   logic                  sclk1;
   logic                  sclk2;
   logic                  lat;
   logic                  spi_so;
   logic                  cen;
   logic [ADDR_WIDTH-1:0] a;
   logic                  d_we;
   logic [DATA_WIDTH-1:0] po;
   logic                  spi_mux;
   logic                  spi_is_done;

   modport slave (
      input  bgn, mode, addr_bgn, data_len, freq_div, pi, spi_si,
      output sclk1, sclk2, lat, spi_so, cen, a, d_we, po, spi_mux, spi_is_done
   );

   modport master (
      output bgn, mode, addr_bgn, data_len, freq_div, pi, spi_si,
      input  sclk1, sclk2, lat, spi_so, cen, a, d_we, po, spi_mux, spi_is_done
   );
endinterface

// File: rtl/pseudo_spi_xfer_ctrl.sv
// Block mover between SRAM and a two-phase serial scan port; read mode shifts SRAM words out,
// write mode shifts words in and stores them. All outputs are registered from next-state values.
module pseudo_spi_xfer_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned DIV_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   pseudo_spi_xfer_ctrl_if.slave bus_io
);
   localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_READ, S_SHIFT, S_LOOP, S_WRITE, S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic                  bgn_q;
   logic                  mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0]  freq_q, freq_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [1:0]            phase_q, phase_d;
   logic [BIT_CNT_W-1:0]  bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

   logic                  sclk1_q, sclk1_d, sclk2_q, sclk2_d;
   logic                  lat_q, lat_d, so_q, so_d;
   logic                  cen_q, cen_d, d_we_q, d_we_d;
   logic [ADDR_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] po_q, po_d;
   logic                  mux_q, mux_d, done_q, done_d;

   logic start_c;
   logic phase_end_c;

   assign start_c     = bus_io.bgn & ~bgn_q & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign phase_end_c = (div_q == freq_q);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         bgn_q   <= 1'b0;
         mode_q  <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         freq_q  <= '0;
         div_q   <= '0;
         phase_q <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sclk1_q <= 1'b0;
         sclk2_q <= 1'b0;
         lat_q   <= 1'b0;
         so_q    <= 1'b0;
         cen_q   <= 1'b1;
         d_we_q  <= 1'b0;
         a_q     <= '0;
         po_q    <= '0;
         mux_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bgn_q   <= bus_io.bgn;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         freq_q  <= freq_d;
         div_q   <= div_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         sclk1_q <= sclk1_d;
         sclk2_q <= sclk2_d;
         lat_q   <= lat_d;
         so_q    <= so_d;
         cen_q   <= cen_d;
         d_we_q  <= d_we_d;
         a_q     <= a_d;
         po_q    <= po_d;
         mux_q   <= mux_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      freq_d  = freq_q;
      div_d   = div_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      lat_d   = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            // div_q doubles as the LAT timer while in DONE
            if (state_q == S_DONE && !phase_end_c) begin
               div_d = div_q + DIV_WIDTH'(1);
               lat_d = 1'b1;
            end
            if (start_c) begin
               mode_d = bus_io.mode;
               addr_d = bus_io.addr_bgn + ADDR_WIDTH'(1);
               cnt_d  = bus_io.data_len;
               freq_d = bus_io.freq_div;
               div_d  = '0;
               if (bus_io.data_len == '0) begin
                  state_d = S_DONE;
                  lat_d   = 1'b1;
               end else begin
                  state_d = S_ADDR;
                  lat_d   = 1'b0;
               end
            end
         end
         S_ADDR: begin
            state_d = mode_q ? S_SHIFT : S_READ;
            div_d   = '0;
            phase_d = '0;
            bit_d   = '0;
         end
         S_READ: begin
            state_d = S_SHIFT;
            shreg_d = bus_io.pi;
            div_d   = '0;
            phase_d = '0;
            bit_d   = '0;
         end
         S_SHIFT: begin
            if (!phase_end_c) begin
               div_d = div_q + DIV_WIDTH'(1);
            end else begin
               div_d   = '0;
               phase_d = phase_q + 2'd1;
               if (phase_q == 2'd2 && mode_q) begin
                  shreg_d = {bus_io.spi_si, shreg_q[DATA_WIDTH-1:1]};
               end
               if (phase_q == 2'd3) begin
                  if (!mode_q) begin
                     shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                  end
                  bit_d = bit_q + BIT_CNT_W'(1);
                  if (bit_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                     state_d = S_LOOP;
                  end
               end
            end
         end
         S_LOOP, S_WRITE: begin
            if (state_q == S_LOOP && mode_q) begin
               state_d = S_WRITE;
            end else begin
               cnt_d  = cnt_q - LEN_WIDTH'(1);
               addr_d = addr_q + ADDR_WIDTH'(1);
               div_d  = '0;
               if (cnt_q == LEN_WIDTH'(1)) begin
                  state_d = S_DONE;
                  lat_d   = 1'b1;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs follow the state being entered so they line up with it after the register
      cen_d   = !((state_d == S_ADDR && !mode_d) || state_d == S_WRITE);
      d_we_d  = (state_d == S_WRITE);
      a_d     = cen_d ? a_q : addr_d;
      po_d    = (state_d == S_WRITE) ? shreg_d : po_q;
      so_d    = (state_d == S_SHIFT) && shreg_d[0];
      sclk1_d = (state_d == S_SHIFT) && (phase_d == 2'd0);
      sclk2_d = (state_d == S_SHIFT) && (phase_d == 2'd2);
      mux_d   = !(state_d == S_IDLE || state_d == S_DONE);
      done_d  = (state_d == S_DONE);
   end

   assign bus_io.sclk1       = sclk1_q;
   assign bus_io.sclk2       = sclk2_q;
   assign bus_io.lat         = lat_q;
   assign bus_io.spi_so      = so_q;
   assign bus_io.cen         = cen_q;
   assign bus_io.a           = a_q;
   assign bus_io.d_we        = d_we_q;
   assign bus_io.po          = po_q;
   assign bus_io.spi_mux     = mux_q;
   assign bus_io.spi_is_done = done_q;
endmodule

// File: doc/pseudo_spi_xfer_ctrl.md
# pseudo_spi_xfer_ctrl

Parametrised successor of the pseudo-SPI interface: moves a block of words between the on-chip SRAM and a two-phase serial scan port. Supports two modes. In read mode it reads SRAM and shifts each word out. In write mode it shifts words in and writes them to SRAM. Word width, address width, length width and serial clock divider are all programmable. It sits between the CPU/test controller (BGN, config) and the SRAM port (CEN, A, D_WE, PI/PO), and drives the external SCLK1/SCLK2/LAT chain.

## Interface
- DATA_WIDTH, 8, bits per SRAM word and per serial word
- ADDR_WIDTH, 10, SRAM address width
- LEN_WIDTH, 8, width of word-count input
- DIV_WIDTH, 8, width of clock-divider input
- CLK  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- BGN  in  1  start request, rising-edge detected
- MODE  in  1  0 = SRAM→serial (read), 1 = serial→SRAM (write)
- ADDR_BGN  in  ADDR_WIDTH  base address; first access is ADDR_BGN+1
- DATA_LEN  in  LEN_WIDTH  number of words to transfer
- FREQ_DIV  in  DIV_WIDTH  each serial phase lasts FREQ_DIV+1 CLK cycles
- PI  in  DATA_WIDTH  SRAM read data, valid 1 cycle after CEN=0 with D_WE=0
- SPI_SI  in  1  serial input, write mode
- SCLK1, SCLK2  out  1  non-overlapping two-phase shift clocks
- LAT  out  1  latch/select strobe after the last word
- SPI_SO  out  1  serial output, LSB first
- CEN  out  1  SRAM chip enable, active low
- A  out  ADDR_WIDTH  SRAM address
- D_WE  out  1  SRAM write enable, 1 = write
- PO  out  DATA_WIDTH  SRAM write data
- spi_MUX  out  1  high while busy; hands the SRAM port to this block
- spi_is_done  out  1  high in DONE; cleared by the next accepted start

## Operation
- Reset values: all outputs 0 except CEN=1. State = IDLE.
- MODE, ADDR_BGN, DATA_LEN and FREQ_DIV are latched on the accepted start. Later input changes have no effect until the next start.
- A start is a BGN rising edge while in IDLE or DONE. BGN edges in any other state are ignored.
- Address register loads ADDR_BGN+1 modulo 2^ADDR_WIDTH and increments after every word. It wraps from all-ones to 0.
- States and transitions:
  - IDLE: wait for start. Go to ADDR, or to DONE if DATA_LEN=0 (no SRAM access in that case).
  - ADDR: 1 cycle. Read mode drives CEN=0, D_WE=0, A=addr, then goes to READ. Write mode goes straight to SHIFT.
  - READ: 1 cycle. Captures PI into the shift register, then goes to SHIFT.
  - SHIFT: sends DATA_WIDTH bits. Each bit lasts four phases of (FREQ_DIV+1) cycles: SCLK1 high, gap, SCLK2 high, gap.
    - SPI_SO = shreg[0] for the whole bit.
    - In write mode, SPI_SI is sampled on the last cycle of the SCLK2-high phase and shifted in at the MSB (right shift).
    - After the last bit, go to LOOP.
  - LOOP: 1 cycle. Write mode goes to WRITE. Read mode decrements the word count and goes to ADDR if the count is nonzero, else to DONE.
  - WRITE: 1 cycle. Drives CEN=0, D_WE=1, A=addr, PO=shreg. Decrements the word count, then goes to ADDR or DONE.
  - DONE: LAT is high for the first FREQ_DIV+1 cycles. spi_is_done=1. spi_MUX=0. Stays in DONE until the next start.
- CEN is 1 in every cycle not listed above. D_WE is 0 whenever CEN=1.
- An rst_n assertion mid-transfer forces IDLE immediately and all outputs to reset values. No partial SRAM write completes after reset.

## Timing
- Accepted start at edge 0: ADDR at cycle 1, first SO bit valid at cycle 3 (read mode).
- Read word period: 3 + 4·DATA_WIDTH·(FREQ_DIV+1) cycles (ADDR + READ + SHIFT + LOOP).
- Write word period: 3 + 4·DATA_WIDTH·(FREQ_DIV+1) cycles (ADDR + SHIFT + LOOP + WRITE).
- SCLK1 and SCLK2 are never high in the same cycle. At least FREQ_DIV+1 low cycles separate them.
- spi_is_done rises 1 cycle after the final LOOP (read) or WRITE (write).

## Test plan
- Read, DW=8, AW=10, ADDR_BGN=0x3FF, DATA_LEN=14, FREQ_DIV=0. SRAM[0..13] = AB,00,00,3C,00,05,3D,9E,C3,D7,58,7A,01,C2 → SO reassembled LSB-first matches all 14 bytes; A sequence 0..13; spi_is_done after 14·35 cycles.
- Write, ADDR_BGN=0x0FF, DATA_LEN=3, SI stream 0x5A,0xC3,0x01 LSB-first → SRAM[0x100..0x102] = 5A,C3,01; exactly 3 D_WE pulses.
- DATA_LEN=0 → DONE 1 cycle after start; CEN never low; LAT pulses once.
- FREQ_DIV=3 → each SCLK1/SCLK2 high for 4 cycles; bit period 16 cycles; no overlap.
- Wrap: ADDR_BGN=0x3FE, DATA_LEN=3 → addresses 0x3FF, 0x000, 0x001.
- rst_n low during word 2 of a write, and BGN pulsed mid-transfer → immediate IDLE with CEN=1 and no further D_WE; a mid-transfer BGN is ignored without re-latching.
